multi_vector_constructor: RTL and testbench
===========================================

// Module: multi_vector_constructor
// PURPOSE
//  Fetches NUM_CHANNELS operand streams from one shared memory read port and emits them as tuples of
//  VECTOR_DIMENSION-element vectors (one vector per channel) under a valid/ready handshake.
//  Generalises the two-operand constructor in the vector-multiplier datapath to N channels with
//  configurable read latency and backpressure. Sits between operand RAM and the multiplier array.
//  Channel 0 is primary; shorter secondary channels wrap to their first vector.
// PARAMETERS
//  ELEMENT_WIDTH     24  bits per element
//  ADDR_WIDTH        17  memory address width; also the width of each element count
//  VECTOR_DIMENSION  3   elements per vector (D)
//  NUM_CHANNELS      2   operand channels (N), >=1
//  READ_LATENCY      1   cycles from mem_rd_en to valid mem_data, >=1
// PORTS
//  clk                clk   in   1                 rising-edge clock
//  reset              rst   in   1                 asynchronous, active-low reset
//  start              in    1                      pulse; latches expected_elements, begins run
//  expected_elements  in    N*ADDR_WIDTH           per-channel element count; ch c at [c*AW +: AW]
//  mem_rd_en          out   1                      read strobe, one address per cycle
//  mem_addr           out   ADDR_WIDTH             read address
//  mem_data           in    ELEMENT_WIDTH          read data, READ_LATENCY cycles after mem_rd_en
//  out_vectors        out   N*D*ELEMENT_WIDTH      ch c element e at [(c*D+e)*EW +: EW]
//  out_valid          out   1                      tuple valid
//  out_ready          in    1                      consumer accepts tuple when out_valid & out_ready
//  busy               out   1                      high from start acceptance until DONE
//  done               out   1                      level; high after last tuple accepted, until next start
//  error              out   1                      level; bad configuration, cleared by next start
// BEHAVIOUR
//  Reset (reset low, async): state IDLE; every output 0; counters, base regs, tag pipe cleared.
//  Regions: base[0]=0, base[c]=sum(expected[0..c-1]) mod 2^ADDR_WIDTH, computed when start accepted.
//  V[c]=expected[c]/D. Tuple count T=V[0]. Tuple t uses ch0 vector t, ch c vector (t mod V[c]).
//  FSM: IDLE, FETCH, DRAIN, PRESENT, DONE.
//  - IDLE/DONE: start=1 latches counts, clears done/error. If any expected[c]==0 or
//    expected[c]%D!=0 -> DONE with error=1, done=1, no reads; else FETCH, busy=1.
//  - start in FETCH/DRAIN/PRESENT ignored.
//  - FETCH: N*D cycles, mem_rd_en=1 each; order ch0 e0..eD-1, ch1 e0.., ...;
//    mem_addr=base[c]+vidx[c]*D+e (mod 2^ADDR_WIDTH). Then DRAIN.
//  - A READ_LATENCY-deep tag pipe (channel, element) steers mem_data into out_vectors slot.
//  - DRAIN: mem_rd_en=0; when last tag's data is written, out_valid=1 next cycle -> PRESENT.
//    Tuple latency: start/accept to out_valid = N*D+READ_LATENCY+1 cycles.
//  - PRESENT: out_valid and out_vectors held stable until out_ready. On handshake: out_valid=0;
//    vidx[0]++; vidx[c]++ or wrap to 0 when it reaches V[c]; if T tuples done -> DONE
//    (busy=0, done=1) else FETCH next cycle. No reads issued while PRESENT (no prefetch).
//  - out_ready while out_valid=0 has no effect.
//  out_vectors retain last tuple after DONE until overwritten by next run's data.
//  Reset mid-run: immediate abort, all outputs 0; in-flight mem_data ignored.
// TESTING
//  1 N=2,D=3,LAT=1, exp={6,3}, mem[a]=a+100, out_ready=1 -> reads 0,1,2,6,7,8,3,4,5,6,7,8;
//    tuples ({100,101,102},{106,107,108}),({103,104,105},{106,107,108}); done=1, busy=0.
//  2 As 1, out_ready held 0 for 5 cycles in PRESENT -> out_valid=1, out_vectors stable, mem_rd_en=0.
//  3 exp={6,4} -> error=1, done=1 one cycle after start, mem_rd_en never asserted; exp={0,3} same.
//  4 N=3,LAT=2, exp={3,3,3} -> reads 0..8, single tuple, out_valid exactly 2+9+1 cycles after start.
//  5 reset low during FETCH of case 1 -> all outputs 0 asynchronously; fresh start reruns case 1 clean.
//  6 start pulsed during PRESENT -> ignored; sequence and done identical to case 1.

Source files
------------

// File: rtl/multi_vector_constructor.sv
// multi_vector_constructor: fetches N operand channels from one shared read
// port and presents them as a tuple of D-element vectors under valid/ready.
//
// Ports:
//   clk, reset (async, active-low)
//   start, expected_elements[N*AW]      run control and per-channel counts
//   mem_rd_en, mem_addr, mem_data       shared memory read port
//   out_vectors, out_valid, out_ready   tuple output handshake
//   busy, done, error                   run status levels
module multi_vector_constructor #(
  parameter int ELEMENT_WIDTH    = 24,
  parameter int ADDR_WIDTH       = 17,
  parameter int VECTOR_DIMENSION = 3,
  parameter int NUM_CHANNELS     = 2,
  parameter int READ_LATENCY     = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] expected_elements,
  output logic mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [ELEMENT_WIDTH-1:0] mem_data,
  output logic [NUM_CHANNELS*VECTOR_DIMENSION*ELEMENT_WIDTH-1:0] out_vectors,
  output logic out_valid,
  input  logic out_ready,
  output logic busy,
  output logic done,
  output logic error
);

  localparam int EW = ELEMENT_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int D  = VECTOR_DIMENSION;
  localparam int N  = NUM_CHANNELS;
  localparam int L  = READ_LATENCY;

  localparam int CHW = (N > 1) ? $clog2(N) : 1;
  localparam int ELW = (D > 1) ? $clog2(D) : 1;

  localparam logic [AW-1:0] D_AW = AW'(D);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0] state;

  logic [AW-1:0] base_q [N];
  logic [AW-1:0] vcnt_q [N];
  logic [AW-1:0] vidx_q [N];

  logic [CHW-1:0] ch_cnt;
  logic [ELW-1:0] el_cnt;

  logic           tag_v    [L];
  logic           tag_last [L];
  logic [CHW-1:0] tag_ch   [L];
  logic [ELW-1:0] tag_el   [L];
  logic           wr_last_q;

  // start-time configuration decode
  logic [AW-1:0] exp_c  [N];
  logic [AW-1:0] base_c [N];
  logic [AW-1:0] vcnt_c [N];
  logic [AW-1:0] acc;
  logic          cfg_bad;

  always_comb begin
    acc     = '0;
    cfg_bad = 1'b0;
    for (int c = 0; c < N; c++) begin
      exp_c[c]  = expected_elements[c*AW +: AW];
      base_c[c] = acc;
      acc       = acc + exp_c[c];
      vcnt_c[c] = exp_c[c] / D_AW;
      if (exp_c[c] == '0 || (exp_c[c] % D_AW) != '0)
        cfg_bad = 1'b1;
    end
  end

  logic          fetching;
  logic          fetch_last;
  logic [AW-1:0] rd_addr;
  logic          hs;
  logic          last_tuple;

  assign fetching   = (state == S_FETCH);
  assign fetch_last = (ch_cnt == CHW'(N-1)) && (el_cnt == ELW'(D-1));
  assign rd_addr    = base_q[ch_cnt]
                    + vidx_q[ch_cnt] * D_AW
                    + AW'(el_cnt);
  assign hs         = (state == S_PRESENT) && out_ready;
  assign last_tuple = (vidx_q[0] + AW'(1)) == vcnt_q[0];

  assign mem_rd_en = fetching;
  assign mem_addr  = fetching ? rd_addr : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ch_cnt    <= '0;
      el_cnt    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      for (int c = 0; c < N; c++) begin
        base_q[c] <= '0;
        vcnt_q[c] <= '0;
        vidx_q[c] <= '0;
      end
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int c = 0; c < N; c++) begin
              base_q[c] <= base_c[c];
              vcnt_q[c] <= vcnt_c[c];
              vidx_q[c] <= '0;
            end
            ch_cnt <= '0;
            el_cnt <= '0;
            if (cfg_bad) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              state <= S_FETCH;
              busy  <= 1'b1;
              done  <= 1'b0;
              error <= 1'b0;
            end
          end
        end
        S_FETCH: begin
          if (el_cnt == ELW'(D-1)) begin
            el_cnt <= '0;
            ch_cnt <= fetch_last ? '0 : ch_cnt + CHW'(1);
          end else begin
            el_cnt <= el_cnt + ELW'(1);
          end
          if (fetch_last)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (wr_last_q) begin
            out_valid <= 1'b1;
            state     <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (hs) begin
            out_valid <= 1'b0;
            vidx_q[0] <= vidx_q[0] + AW'(1);
            for (int c = 1; c < N; c++) begin
              if (vidx_q[c] + AW'(1) == vcnt_q[c])
                vidx_q[c] <= '0;
              else
                vidx_q[c] <= vidx_q[c] + AW'(1);
            end
            if (last_tuple) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // tag pipe tracks which slot each outstanding read belongs to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_last_q <= 1'b0;
      for (int k = 0; k < L; k++) begin
        tag_v[k]    <= 1'b0;
        tag_last[k] <= 1'b0;
        tag_ch[k]   <= '0;
        tag_el[k]   <= '0;
      end
    end else begin
      tag_v[0]    <= fetching;
      tag_last[0] <= fetching && fetch_last;
      tag_ch[0]   <= ch_cnt;
      tag_el[0]   <= el_cnt;
      for (int k = 1; k < L; k++) begin
        tag_v[k]    <= tag_v[k-1];
        tag_last[k] <= tag_last[k-1];
        tag_ch[k]   <= tag_ch[k-1];
        tag_el[k]   <= tag_el[k-1];
      end
      wr_last_q <= tag_v[L-1] && tag_last[L-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vectors <= '0;
    end else if (tag_v[L-1]) begin
      for (int c = 0; c < N; c++) begin
        for (int e = 0; e < D; e++) begin
          if (tag_ch[L-1] == CHW'(c) && tag_el[L-1] == ELW'(e))
            out_vectors[(c*D+e)*EW +: EW] <= mem_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_vector_constructor.sv
// tb_multi_vector_constructor: scoreboard bench for multi_vector_constructor,
// one N=2/LAT=1 instance and one N=3/LAT=2 instance on a shared clock.
module tb_multi_vector_constructor;

  localparam int EW = 24;
  localparam int AW = 17;
  localparam int D  = 3;
  localparam int BUDGET = 500;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance A: N=2, LAT=1
  logic              a_start = 1'b0;
  logic [2*AW-1:0]   a_exp = '0;
  logic              a_rd_en;
  logic [AW-1:0]     a_addr;
  logic [EW-1:0]     a_data;
  logic [2*D*EW-1:0] a_vec;
  logic              a_valid;
  logic              a_ready = 1'b1;
  logic              a_busy, a_done, a_error;

  multi_vector_constructor #(
    .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .VECTOR_DIMENSION(D),
    .NUM_CHANNELS(2), .READ_LATENCY(1)
  ) dut_a (
    .clk(clk), .reset(reset), .start(a_start),
    .expected_elements(a_exp),
    .mem_rd_en(a_rd_en), .mem_addr(a_addr), .mem_data(a_data),
    .out_vectors(a_vec), .out_valid(a_valid), .out_ready(a_ready),
    .busy(a_busy), .done(a_done), .error(a_error)
  );

  logic [AW-1:0] a_p0 = '0;
  always @(posedge clk) a_p0 <= a_addr;
  assign a_data = EW'(a_p0) + EW'(100);

  // instance B: N=3, LAT=2
  logic              b_start = 1'b0;
  logic [3*AW-1:0]   b_exp = '0;
  logic              b_rd_en;
  logic [AW-1:0]     b_addr;
  logic [EW-1:0]     b_data;
  logic [3*D*EW-1:0] b_vec;
  logic              b_valid;
  logic              b_ready = 1'b1;
  logic              b_busy, b_done, b_error;

  multi_vector_constructor #(
    .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .VECTOR_DIMENSION(D),
    .NUM_CHANNELS(3), .READ_LATENCY(2)
  ) dut_b (
    .clk(clk), .reset(reset), .start(b_start),
    .expected_elements(b_exp),
    .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_data(b_data),
    .out_vectors(b_vec), .out_valid(b_valid), .out_ready(b_ready),
    .busy(b_busy), .done(b_done), .error(b_error)
  );

  logic [AW-1:0] b_p0 = '0;
  logic [AW-1:0] b_p1 = '0;
  always @(posedge clk) begin
    b_p0 <= b_addr;
    b_p1 <= b_p0;
  end
  assign b_data = EW'(b_p1) + EW'(100);

  logic [AW-1:0]  a_rdq [$];
  logic [AW-1:0]  b_rdq [$];
  logic [255:0]   a_tq  [$];
  logic [255:0]   b_tq  [$];

  task automatic check(input string name,
                       input logic [255:0] got,
                       input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // read-address and tuple scoreboards
  always @(negedge clk) begin
    if (reset && a_rd_en) begin
      if (a_rdq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_rd_unexpected: addr %0h, none expected", a_addr);
      end else begin
        check("a_rd_addr", 256'(a_addr), 256'(a_rdq.pop_front()));
      end
    end
    if (reset && a_valid && a_ready) begin
      if (a_tq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_tuple_unexpected: got %0h", a_vec);
      end else begin
        check("a_tuple", 256'(a_vec), a_tq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (reset && b_rd_en) begin
      if (b_rdq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_rd_unexpected: addr %0h, none expected", b_addr);
      end else begin
        check("b_rd_addr", 256'(b_addr), 256'(b_rdq.pop_front()));
      end
    end
    if (reset && b_valid && b_ready) begin
      if (b_tq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_tuple_unexpected: got %0h", b_vec);
      end else begin
        check("b_tuple", 256'(b_vec), b_tq.pop_front());
      end
    end
  end

  // expected reads and tuples for instance A, mem[a] = a + 100
  task automatic push_a(input logic [AW-1:0] e0, input logic [AW-1:0] e1);
    int v0;
    int v1;
    int vi [2];
    logic [AW-1:0] base [2];
    logic [AW-1:0] ad;
    logic [255:0] tup;
    v0 = int'(e0) / D;
    v1 = int'(e1) / D;
    base[0] = '0;
    base[1] = e0;
    for (int t = 0; t < v0; t++) begin
      tup = '0;
      vi[0] = t;
      vi[1] = t % v1;
      for (int c = 0; c < 2; c++) begin
        for (int e = 0; e < D; e++) begin
          ad = base[c] + AW'(vi[c] * D + e);
          a_rdq.push_back(ad);
          tup[(c*D+e)*EW +: EW] = EW'(ad) + EW'(100);
        end
      end
      a_tq.push_back(tup);
    end
  endtask

  task automatic pulse_a(input logic [AW-1:0] e0, input logic [AW-1:0] e1);
    @(posedge clk);
    #1;
    a_exp   = {e1, e0};
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(output int lat);
    int n;
    lat = -1;
    for (n = 1; n <= BUDGET; n++) begin
      @(posedge clk);
      #1;
      if (a_valid && lat < 0) lat = n;
      if (a_done) break;
    end
    if (n > BUDGET) check("a_timeout_done", 256'(a_done), 256'(1));
  endtask

  task automatic final_a(input string tag);
    check({tag, "_done"}, 256'(a_done), 256'(1));
    check({tag, "_busy"}, 256'(a_busy), 256'(0));
    check({tag, "_valid"}, 256'(a_valid), 256'(0));
    check({tag, "_rdq_left"}, 256'(a_rdq.size()), 256'(0));
    check({tag, "_tq_left"}, 256'(a_tq.size()), 256'(0));
  endtask

  task automatic run_a(input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                       input bit err, output int lat);
    lat = -1;
    if (!err) push_a(e0, e1);
    pulse_a(e0, e1);
    if (err) begin
      check("a_err_error", 256'(a_error), 256'(1));
      check("a_err_done", 256'(a_done), 256'(1));
      check("a_err_busy", 256'(a_busy), 256'(0));
      repeat (4) @(posedge clk);
      #1;
      check("a_err_hold", 256'({a_error, a_done}), 256'(3));
    end else begin
      check("a_run_busy", 256'(a_busy), 256'(1));
      check("a_run_done_clr", 256'({a_done, a_error}), 256'(0));
      wait_done_a(lat);
      check("a_run_error", 256'(a_error), 256'(0));
      final_a("a_run");
    end
  endtask

  typedef struct {
    logic [AW-1:0] e0;
    logic [AW-1:0] e1;
    bit            err;
  } vec_t;

  vec_t tbl [8];

  initial begin : main
    int lat;
    int n;
    logic [2*D*EW-1:0] snap;
    logic [255:0] tup;

    tbl[0] = '{e0: 17'd6,  e1: 17'd3, err: 1'b0};
    tbl[1] = '{e0: 17'd6,  e1: 17'd4, err: 1'b1};
    tbl[2] = '{e0: 17'd0,  e1: 17'd3, err: 1'b1};
    tbl[3] = '{e0: 17'd9,  e1: 17'd6, err: 1'b0};
    tbl[4] = '{e0: 17'd3,  e1: 17'd6, err: 1'b0};
    tbl[5] = '{e0: 17'd12, e1: 17'd9, err: 1'b0};
    tbl[6] = '{e0: 17'd3,  e1: 17'd0, err: 1'b1};
    tbl[7] = '{e0: 17'd7,  e1: 17'd3, err: 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_a_ctrl", 256'({a_rd_en, a_valid, a_busy, a_done, a_error}),
          256'(0));
    check("rst_a_addr", 256'(a_addr), 256'(0));
    check("rst_a_vec", 256'(a_vec), 256'(0));
    check("rst_b_ctrl", 256'({b_rd_en, b_valid, b_busy, b_done, b_error}),
          256'(0));
    reset = 1'b1;

    // basic run with tuple latency
    run_a(17'd6, 17'd3, 1'b0, lat);
    check("a_latency", 256'(lat), 256'(8));

    // configuration table
    for (int i = 0; i < 8; i++) begin
      run_a(tbl[i].e0, tbl[i].e1, tbl[i].err, lat);
      if (!tbl[i].err) check("a_tbl_latency", 256'(lat), 256'(8));
    end

    // backpressure in PRESENT, with an ignored start pulse
    a_ready = 1'b0;
    push_a(17'd6, 17'd3);
    pulse_a(17'd6, 17'd3);
    for (n = 0; n < BUDGET && !a_valid; n++) begin
      @(posedge clk);
      #1;
    end
    check("stall_reach_valid", 256'(a_valid), 256'(1));
    snap = a_vec;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 256'(a_valid), 256'(1));
      check("stall_vec", 256'(a_vec), 256'(snap));
      check("stall_rd_en", 256'(a_rd_en), 256'(0));
      if (k == 1) begin
        a_exp   = {17'd3, 17'd3};
        a_start = 1'b1;
      end else begin
        a_start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    a_start = 1'b0;
    check("stall_busy", 256'(a_busy), 256'(1));
    a_ready = 1'b1;
    wait_done_a(lat);
    check("stall_error", 256'(a_error), 256'(0));
    final_a("stall");

    // instance B: three channels, read latency 2
    tup = '0;
    for (int i = 0; i < 9; i++) begin
      b_rdq.push_back(AW'(i));
      tup[i*EW +: EW] = EW'(i + 100);
    end
    b_tq.push_back(tup);
    @(posedge clk);
    #1;
    b_exp   = {17'd3, 17'd3, 17'd3};
    b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    lat = -1;
    for (n = 1; n <= BUDGET; n++) begin
      @(posedge clk);
      #1;
      if (b_valid && lat < 0) lat = n;
      if (b_done) break;
    end
    check("b_latency", 256'(lat), 256'(12));
    check("b_done", 256'({b_done, b_busy, b_error}), 256'(4));
    check("b_rdq_left", 256'(b_rdq.size()), 256'(0));
    check("b_tq_left", 256'(b_tq.size()), 256'(0));

    // asynchronous reset in the middle of FETCH
    push_a(17'd6, 17'd3);
    pulse_a(17'd6, 17'd3);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_ctrl", 256'({a_rd_en, a_valid, a_busy, a_done, a_error}),
          256'(0));
    check("arst_addr", 256'(a_addr), 256'(0));
    check("arst_vec", 256'(a_vec), 256'(0));
    a_rdq.delete();
    a_tq.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_a(17'd6, 17'd3, 1'b0, lat);
    check("arst_rerun_latency", 256'(lat), 256'(8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
